text_attrib_gen: RTL

TEXT_ATTRIB_GEN -- requirements
Module: text_attrib_gen

---
 rtl/text_attrib_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/text_attrib_gen.sv
// Text-mode attribute generator for an MDA/CGA style display.
// Decodes the attribute byte of the current character into a
// registered RGBI pixel plus mono video/intensity dots. Cursor and
// character blink are timed from vsync through a frame counter.

module text_attrib_gen #(
    parameter int MODE      = 0,
    parameter int ROW_W     = 5,
    parameter int UL_ROW    = 12,
    parameter int BLINK_DIV = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       att_byte,
    input  logic [ROW_W-1:0] row_addr,
    input  logic             display_enable,
    input  logic             blink_enabled,
    input  logic             vsync,
    input  logic             cursor,
    input  logic             pix_in,
    output logic [3:0]       rgbi_out,
    output logic             video_out,
    output logic             intensity_out
);

    // Last frame-counter value before it wraps back to zero.
    localparam logic [7:0]       FC_LAST  = 8'(BLINK_DIV - 1);
    // Scanline that carries the MDA underline, sized to row_addr.
    localparam logic [ROW_W-1:0] UL_ROW_V = ROW_W'(UL_ROW);

    // Blink timebase state.
    logic       vsync_q, vsync_d;
    logic [7:0] fc_q, fc_d;
    logic       cursor_phase_q, cursor_phase_d;
    logic       char_phase_q, char_phase_d;
    logic       vsync_rise;
    logic       fc_wrap;

    // Output registers.
    logic [3:0] rgbi_q, rgbi_d;
    logic       video_q, video_d;
    logic       intensity_q, intensity_d;

    // Shared pixel terms.
    logic       cursor_vis;
    logic       blink_area;

    // Monochrome decode terms.
    logic [2:0] mda_fg;
    logic [2:0] mda_bg;
    logic       underline;
    logic       inverse;
    logic       nodisp;
    logic       mda_dots;
    logic       mda_video;
    logic       mda_intensity;

    // Colour decode terms, {I,R,G,B} ordering until the final reorder.
    logic [3:0] cga_fgc;
    logic [3:0] cga_bgc;
    logic [3:0] cga_sel;
    logic       cga_dots;
    logic [3:0] cga_rgbi;

    // Count vsync rising edges; each wrap flips the cursor phase and
    // every 0->1 cursor transition flips the character phase.
    always_comb begin
        vsync_d        = vsync;
        vsync_rise     = vsync & ~vsync_q;
        fc_wrap        = vsync_rise && (fc_q == FC_LAST);
        fc_d           = fc_q;
        if (vsync_rise) begin
            fc_d = fc_wrap ? 8'd0 : fc_q + 8'd1;
        end
        cursor_phase_d = cursor_phase_q ^ fc_wrap;
        char_phase_d   = char_phase_q ^ (fc_wrap & ~cursor_phase_q);
    end

    // Resolve the attribute byte into a pixel for both display modes,
    // then pick the one this instance is built for.
    always_comb begin
        cursor_vis    = cursor & cursor_phase_q;
        blink_area    = att_byte[7] & char_phase_q & ~cursor & blink_enabled;

        mda_fg        = att_byte[2:0];
        mda_bg        = att_byte[6:4];
        underline     = (mda_fg == 3'b001) && (row_addr == UL_ROW_V);
        inverse       = (mda_fg == 3'b000) && (mda_bg == 3'b111);
        nodisp        = (mda_fg == 3'b000) && (mda_bg == 3'b000);
        mda_dots      = ((pix_in | underline) & ~nodisp & ~blink_area) | cursor_vis;
        mda_video     = (mda_dots ^ inverse) & display_enable;
        mda_intensity = (mda_dots ? att_byte[3] : (att_byte[7] & ~blink_enabled))
                        & display_enable;

        cga_fgc       = att_byte[3:0];
        cga_bgc       = {att_byte[7] & ~blink_enabled, att_byte[6:4]};
        cga_dots      = (pix_in & ~blink_area) | cursor_vis;
        cga_sel       = cga_dots ? cga_fgc : cga_bgc;
        cga_rgbi      = display_enable ? {cga_sel[2:0], cga_sel[3]} : 4'b0000;

        if (MODE == 0) begin
            rgbi_d      = {mda_video, mda_video, mda_video, mda_intensity};
            video_d     = mda_video;
            intensity_d = mda_intensity;
        end else begin
            rgbi_d      = cga_rgbi;
            video_d     = cga_dots & display_enable;
            intensity_d = cga_rgbi[0];
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q        <= 1'b0;
            fc_q           <= 8'd0;
            cursor_phase_q <= 1'b0;
            char_phase_q   <= 1'b0;
            rgbi_q         <= 4'b0000;
            video_q        <= 1'b0;
            intensity_q    <= 1'b0;
        end else begin
            vsync_q        <= vsync_d;
            fc_q           <= fc_d;
            cursor_phase_q <= cursor_phase_d;
            char_phase_q   <= char_phase_d;
            rgbi_q         <= rgbi_d;
            video_q        <= video_d;
            intensity_q    <= intensity_d;
        end
    end

    assign rgbi_out      = rgbi_q;
    assign video_out     = video_q;
    assign intensity_out = intensity_q;

endmodule
